// File: rtl/message_scroller_pkg.sv
// Shared definitions for the scrolling seven-segment message display:
// the message ROM, the refresh FSM state type and the blank segment pattern.
package message_scroller_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Sixteen 4-bit character codes, entry 0 in the least significant nibble.
    localparam logic [63:0] MSG_ROM = 64'hFEDCBA9876543210;

    function automatic logic [3:0] msg_char(input logic [3:0] idx);
        return MSG_ROM[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low, seg[6]=a ... seg[0]=g.
module seg_decoder
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Character code to segment pattern lookup
    always_comb begin
        seg = 7'b1111111;
        case (code)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/message_scroller.sv
// Scrolls a fixed message across four multiplexed seven-segment digits; one
// scroll step per rising edge of spin_in, each digit slot preceded by a blank cycle.
module message_scroller
    import message_scroller_pkg::*;
#(
    parameter int MSG_LEN   = 16,
    parameter int REFRESH_W = 16
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       spin_in,
    input  logic                       pause,
    input  logic                       dir,
    output logic [3:0]                 an,
    output logic [6:0]                 seg,
    output logic [$clog2(MSG_LEN)-1:0] offset
);

    localparam int OW = $clog2(MSG_LEN);

    logic                 spin_prev_r;
    logic [OW-1:0]        offset_r;
    logic [OW-1:0]        offset_nxt_s;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [1:0]           digit_r;
    logic [1:0]           digit_nxt_s;
    logic [REFRESH_W-1:0] slot_r;
    logic [3:0]           an_r;
    logic [3:0]           an_nxt_s;
    logic [6:0]           seg_r;
    logic [6:0]           seg_nxt_s;
    logic                 step_s;
    logic [OW-1:0]        char_idx_s;
    logic [3:0]           code_s;
    logic [6:0]           dec_seg_s;

    assign step_s = spin_in & ~spin_prev_r;

    // Scroll offset update; modular wrap comes free from the power-of-two width
    always_comb begin
        offset_nxt_s = offset_r;
        if (step_s && !pause) begin
            if (dir) begin
                offset_nxt_s = offset_r - OW'(1);
            end else begin
                offset_nxt_s = offset_r + OW'(1);
            end
        end else begin
            offset_nxt_s = offset_r;
        end
    end

    // Refresh FSM: one blank cycle, then drive until the slot counter saturates
    always_comb begin
        state_nxt_s = state_r;
        digit_nxt_s = digit_r;
        case (state_r)
            BLANK: begin
                state_nxt_s = DRIVE;
            end
            DRIVE: begin
                if (slot_r == {REFRESH_W{1'b1}}) begin
                    state_nxt_s = BLANK;
                    digit_nxt_s = digit_r + 2'd1;
                end else begin
                    state_nxt_s = DRIVE;
                end
            end
            default: begin
                state_nxt_s = BLANK;
                digit_nxt_s = 2'd0;
            end
        endcase
    end

    // Digit k (k=3 leftmost) shows message[offset + 3 - k]
    assign char_idx_s = offset_r + OW'(3) - OW'(digit_r);
    assign code_s     = msg_char(4'(char_idx_s));

    seg_decoder u_seg_decoder (
        .code (code_s),
        .seg  (dec_seg_s)
    );

    // Next anode/segment pattern from the current FSM state and offset
    always_comb begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = SEG_BLANK;
        if (state_r == DRIVE) begin
            an_nxt_s  = ~(4'b0001 << digit_r);
            seg_nxt_s = dec_seg_s;
        end else begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = SEG_BLANK;
        end
    end

    // State registers; spin_prev resets high so a level already high is not a step
    always_ff @(posedge clk) begin
        if (reset) begin
            spin_prev_r <= 1'b1;
            offset_r    <= '0;
            state_r     <= BLANK;
            digit_r     <= 2'd0;
            slot_r      <= '0;
            an_r        <= 4'b1111;
            seg_r       <= SEG_BLANK;
        end else begin
            spin_prev_r <= spin_in;
            offset_r    <= offset_nxt_s;
            state_r     <= state_nxt_s;
            digit_r     <= digit_nxt_s;
            slot_r      <= slot_r + {{(REFRESH_W-1){1'b0}}, 1'b1};
            an_r        <= an_nxt_s;
            seg_r       <= seg_nxt_s;
        end
    end

    assign an     = an_r;
    assign seg    = seg_r;
    assign offset = offset_r;

endmodule

// File: tb/tb_message_scroller.sv
// Directed and random stimulus for message_scroller with a cycle-level reference
// model feeding a queue of expected outputs.
module tb_message_scroller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spin_in = 1'b0;
    logic       pause = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] offset;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] off;
    } exp_t;

    exp_t exp_q[$];

    int         m_cyc  = 0;
    logic       m_prev = 1'b1;
    logic [3:0] m_off  = 4'd0;
    exp_t       last_exp;

    message_scroller #(.MSG_LEN(16), .REFRESH_W(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .spin_in (spin_in),
        .pause   (pause),
        .dir     (dir),
        .an      (an),
        .seg     (seg),
        .offset  (offset)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  4'hF: s = 7'b0111000;
            default: s = 7'bxxxxxxx;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock: drive inputs, predict outputs after the edge, compare them.
    task automatic tick(input logic r, input logic s, input logic p, input logic d);
        exp_t e;
        logic blank;
        int   idx;
        reset = r; spin_in = s; pause = p; dir = d;
        blank = ((m_cyc % 4) == 0);
        idx   = (m_cyc / 4) % 4;
        if (r) begin
            e.an = 4'b1111; e.seg = 7'b1111111; e.off = 4'd0;
            m_cyc = 0; m_prev = 1'b1; m_off = 4'd0;
        end else begin
            if (blank) begin
                e.an = 4'b1111; e.seg = 7'b1111111;
            end else begin
                e.an  = ~(4'b0001 << idx);
                e.seg = seg_ref(m_off + 4'd3 - 4'(idx));
            end
            if (s && !m_prev && !p) m_off = d ? m_off - 4'd1 : m_off + 4'd1;
            e.off  = m_off;
            m_prev = s;
            m_cyc  = m_cyc + 1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        last_exp = e;
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("offset", 32'(offset), 32'(e.off));
    endtask

    task automatic step(input logic d);
        tick(1'b0, 1'b1, 1'b0, d);
        tick(1'b0, 1'b0, 1'b0, d);
    endtask

    initial begin
        bit found;
        // Reset, then idle refresh pattern
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("c1_an", 32'(an), 32'h0000000F);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("c2_an", 32'(an), 32'h0000000E);
        chk("c2_seg", 32'(seg), 32'h00000006);
        for (int i = 0; i < 18; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Sixteen left steps, offset wraps back to 0
        step(1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (last_exp.an == 4'b0111) found = 1'b1;
        end
        chk("dig3_found", 32'(found), 32'd1);
        chk("dig3_seg", 32'(seg), 32'h0000004F);
        for (int i = 2; i <= 16; i++) begin
            step(1'b0);
            chk("left_off", 32'(offset), 32'(i % 16));
        end

        // Right step from 0 wraps to 15
        step(1'b1);
        chk("right_wrap", 32'(offset), 32'd15);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Paused edge is dropped, releasing pause with spin high does nothing
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_off", 32'(offset), 32'd15);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // spin_in high across reset release is not a step
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_spin_off", 32'(offset), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("first_step", 32'(offset), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of digit 2's drive slot with offset 7
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("off7", 32'(offset), 32'd7);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if ((m_cyc % 4) == 2 && ((m_cyc / 4) % 4) == 2) found = 1'b1;
            else tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("mid_drive_found", 32'(found), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_an", 32'(an), 32'h0000000F);
        chk("mid_rst_off", 32'(offset), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_c2", 32'(an), 32'h0000000E);

        // Random spin/pause/dir traffic
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/message_scroller.md
MESSAGE_SCROLLER -- requirements
Module: message_scroller

Interface
REQ-001 The module SHALL have parameter MSG_LEN, default 16, giving the message length in characters (power of two, 4..16).
REQ-002 The module SHALL have parameter REFRESH_W, default 16, giving the digit-slot length as 2^REFRESH_W clk cycles.
REQ-003 The module SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port spin_in  input  1  MSB of the free-running delay counter; each rising edge requests one scroll step.
REQ-006 The module SHALL have port pause  input  1  level; while high, scroll requests are discarded.
REQ-007 The module SHALL have port dir  input  1  scroll direction: 0 = left (offset+1), 1 = right (offset-1).
REQ-008 The module SHALL have port an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
REQ-009 The module SHALL have port seg  output  7  segments a..g, active-low (seg[6]=a ... seg[0]=g).
REQ-010 The module SHALL have port offset  output  log2(MSG_LEN)  current window start index, for debug and bench use.

Function
REQ-011 Edge detection: a step event SHALL be flagged on a clk edge where spin_in=1 and the registered spin_prev=0; spin_prev SHALL load spin_in every cycle.
REQ-012 On a step event with pause=0, offset SHALL update on that same clk edge: +1 mod MSG_LEN if dir=0, -1 mod MSG_LEN if dir=1.
REQ-013 Wrap-around: offset SHALL wrap MSG_LEN-1 -> 0 when dir=0 and 0 -> MSG_LEN-1 when dir=1, with no extra step and no stall.
REQ-014 dir and pause SHALL be sampled in the same cycle as the step event; a change in any other cycle has no effect on that step.
REQ-015 A step event with pause=1 SHALL be dropped, not queued; releasing pause SHALL NOT cause a step.
REQ-016 Digit k (k=0..3, k=3 leftmost) SHALL display message[(offset + 3 - k) mod MSG_LEN].
REQ-017 The refresh FSM SHALL have states BLANK and DRIVE and a 2-bit digit index; a REFRESH_W-bit slot counter SHALL increment every cycle.
REQ-018 BLANK SHALL last exactly 1 cycle with an=4'b1111, then move to DRIVE; DRIVE SHALL last until the slot counter reaches all-ones, then move to BLANK with the digit index incremented mod 4 (order 0,1,2,3,0...).
REQ-019 In DRIVE, an SHALL assert only the bit for the digit index, and seg SHALL be the decoded character for that digit.
REQ-020 an and seg SHALL be registered: they reflect the FSM state and offset of the previous cycle, giving 1 cycle of latency.
REQ-021 An offset change during DRIVE SHALL take effect on seg 1 cycle later, without restarting the slot.
REQ-022 Characters SHALL be 4-bit codes decoded as hex 0-9, A, b, C, d, E, F; with all segments lit for 8, and none lit only in BLANK.

Reset
REQ-023 On reset: offset=0, spin_prev=1 (so spin_in already high at reset release is not a step), FSM=BLANK, digit index=0, slot counter=0, an=4'b1111, seg=7'b1111111.
REQ-024 Reset asserted mid-slot or mid-step SHALL override everything on that edge; the first DRIVE after release SHALL be digit 0 at cycle 2.

Structure
REQ-025 The shared package SHALL hold the message ROM constant (MSG_LEN 4-bit codes, default "0123456789AbCdEF" as codes 0..F), the FSM state typedef, and the blank segment constant 7'b1111111.
REQ-026 The hex-to-seven-segment decoder SHALL be a separate combinational sub-module, seg_decoder, with 4-bit code in and 7-bit active-low segments out.

Verification
REQ-027 Reset, then spin_in held 0, REFRESH_W=2 -> an sequence 1111,1110(x3),1111,1101(x3),...; digit 0 seg = decode(3)=7'b0000110.
REQ-028 16 spin_in rising edges, dir=0, pause=0 -> offset 1,2,...,15,0; after the first edge, digit 3 shows '1' (7'b1001111).
REQ-029 offset=0, one edge with dir=1 -> offset=15, digit 0 shows code 2 (15+3 mod 16).
REQ-030 Edge with pause=1, then pause dropped with spin_in held high -> offset unchanged.
REQ-031 spin_in=1 during and after reset release -> no step; first step comes only after spin_in goes 0 then 1.
REQ-032 Reset pulsed mid-DRIVE of digit 2 with offset=7 -> next cycle an=1111, offset=0, digit 0 driven at cycle 2.
